// File: rtl/issue_fifo_pkg.sv
// Shared constants and the reservation-station entry layout carried by the issue FIFOs.
package issue_fifo_pkg;

  localparam int unsigned ISSUE_CH_ALU     = 0;
  localparam int unsigned ISSUE_CH_LS      = 1;
  localparam int unsigned ISSUE_CH_BR      = 2;
  localparam int unsigned ISSUE_NUM_CH     = 3;
  localparam int unsigned ISSUE_FIFO_DEPTH = 4;
  localparam int unsigned ISSUE_AF_LEVEL   = 3;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [6:0]  rob_idx;
    logic [5:0]  dst_preg;
    logic [5:0]  src1_preg;
    logic [5:0]  src2_preg;
    logic [30:0] imm;
  } RS_ENTRY_t;

  localparam int unsigned ISSUE_PAYLOAD_W = $bits(RS_ENTRY_t);

  // Occupancy counters must represent 0..DEPTH inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/issue_fifo_if.sv
// Producer/consumer bus of the multi-channel issue buffer; channel c occupies slice c of each field.
interface issue_fifo_if
  import issue_fifo_pkg::*;
#(
  parameter int unsigned NUM_CH        = ISSUE_NUM_CH,
  parameter int unsigned PAYLOAD_WIDTH = ISSUE_PAYLOAD_W,
  parameter int unsigned DEPTH         = ISSUE_FIFO_DEPTH
);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [NUM_CH-1:0]               in_valid;
  logic [NUM_CH-1:0]               in_ready;
  logic [NUM_CH*PAYLOAD_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]               out_valid;
  logic [NUM_CH-1:0]               out_ready;
  logic [NUM_CH*PAYLOAD_WIDTH-1:0] out_data;
  logic [NUM_CH*CW-1:0]            count;
  logic [NUM_CH-1:0]               almost_full;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, almost_full
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, almost_full
  );

endinterface

// File: rtl/issue_fifo_channel.sv
// Single-channel first-word-fall-through FIFO with count-based full/empty and global flush.
module issue_fifo_channel
  import issue_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH         = ISSUE_FIFO_DEPTH,
  parameter  int unsigned PAYLOAD_WIDTH = ISSUE_PAYLOAD_W,
  parameter  int unsigned AF_LEVEL      = ISSUE_AF_LEVEL,
  localparam int unsigned CW            = cnt_width(DEPTH),
  localparam int unsigned PTR_W         = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [PAYLOAD_WIDTH-1:0] in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [PAYLOAD_WIDTH-1:0] out_data_o,
  output logic [CW-1:0]            count_o,
  output logic                     almost_full_o
);

  logic [PAYLOAD_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     push, pop;

  // Handshake qualifiers come only from registered count and flush.
  assign in_ready_o    = (count_q != CW'(DEPTH)) && !flush_i;
  assign out_valid_o   = (count_q != '0) && !flush_i;
  assign out_data_o    = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign almost_full_o = (count_q >= CW'(AF_LEVEL));
  assign count_o       = count_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale words are hidden by count.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/issue_fifo.sv
// Multi-channel issue buffer: one independent FIFO per issue channel, buses sliced per channel.
module issue_fifo
  import issue_fifo_pkg::*;
#(
  parameter int unsigned NUM_CH        = ISSUE_NUM_CH,
  parameter int unsigned DEPTH         = ISSUE_FIFO_DEPTH,
  parameter int unsigned PAYLOAD_WIDTH = ISSUE_PAYLOAD_W,
  parameter int unsigned AF_LEVEL      = ISSUE_AF_LEVEL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  issue_fifo_if.slave  bus
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic                     ch_in_ready    [NUM_CH];
  logic                     ch_out_valid   [NUM_CH];
  logic [PAYLOAD_WIDTH-1:0] ch_out_data    [NUM_CH];
  logic [CW-1:0]            ch_count       [NUM_CH];
  logic                     ch_almost_full [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    issue_fifo_channel #(
      .DEPTH         (DEPTH),
      .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
      .AF_LEVEL      (AF_LEVEL)
    ) u_channel (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (flush),
      .in_valid_i    (bus.in_valid[c]),
      .in_ready_o    (ch_in_ready[c]),
      .in_data_i     (bus.in_data[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]),
      .out_valid_o   (ch_out_valid[c]),
      .out_ready_i   (bus.out_ready[c]),
      .out_data_o    (ch_out_data[c]),
      .count_o       (ch_count[c]),
      .almost_full_o (ch_almost_full[c])
    );
  end

  // Pack per-channel results back onto the shared bus.
  always_comb begin
    bus.in_ready    = '0;
    bus.out_valid   = '0;
    bus.out_data    = '0;
    bus.count       = '0;
    bus.almost_full = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.in_ready[c]                              = ch_in_ready[c];
      bus.out_valid[c]                             = ch_out_valid[c];
      bus.out_data[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = ch_out_data[c];
      bus.count[c*CW +: CW]                        = ch_count[c];
      bus.almost_full[c]                           = ch_almost_full[c];
    end
  end

endmodule

// File: tb/tb_issue_fifo.sv
// Bench for issue_fifo: directed plan steps then random traffic, checked against per-channel queues.
module tb_issue_fifo;

  localparam int unsigned NCH   = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 64;
  localparam int unsigned AF    = 3;
  localparam int unsigned CW    = 3;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  int n_cmp = 0;
  int n_err = 0;

  logic [PW-1:0] mq [NCH][$];

  issue_fifo_if #(.NUM_CH(NCH), .PAYLOAD_WIDTH(PW), .DEPTH(DEPTH)) bus ();

  issue_fifo #(
    .NUM_CH(NCH), .DEPTH(DEPTH), .PAYLOAD_WIDTH(PW), .AF_LEVEL(AF)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int c, input logic [PW-1:0] v);
    bus.in_data[c*PW +: PW] = v;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int c);
    return bus.count[c*CW +: CW];
  endfunction

  // Expected outputs derived from queue occupancy and head.
  task automatic check_all();
    for (int c = 0; c < NCH; c++) begin
      int n;
      logic [PW-1:0] head;
      n = mq[c].size();
      head = (n != 0) ? mq[c][0] : '0;
      chk($sformatf("in_ready[%0d]", c), 64'(bus.in_ready[c]), 64'((n != DEPTH) && !flush));
      chk($sformatf("out_valid[%0d]", c), 64'(bus.out_valid[c]), 64'((n != 0) && !flush));
      chk($sformatf("out_data[%0d]", c), bus.out_data[c*PW +: PW], head);
      chk($sformatf("count[%0d]", c), 64'(cnt_of(c)), 64'(n));
      chk($sformatf("almost_full[%0d]", c), 64'(bus.almost_full[c]), 64'(n >= AF));
    end
  endtask

  // Check settled outputs, advance one edge, apply the same transfers to the model.
  task automatic step();
    bit do_push [NCH];
    bit do_pop  [NCH];
    #1;
    check_all();
    for (int c = 0; c < NCH; c++) begin
      do_pop[c]  = (mq[c].size() != 0) && bus.out_ready[c] && !flush;
      do_push[c] = (mq[c].size() != DEPTH) && bus.in_valid[c] && !flush;
    end
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (rst || flush) begin
        mq[c].delete();
      end else begin
        if (do_pop[c])  void'(mq[c].pop_front());
        if (do_push[c]) mq[c].push_back(bus.in_data[c*PW +: PW]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid  = '1;
    bus.out_ready = '0;
    bus.in_data   = '0;
    for (int c = 0; c < NCH; c++) set_data(c, 64'hDEAD_0000 + 64'(c));
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held with all producers requesting
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(3'b111));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_count", 64'(bus.count), 64'(0));
    step();
    rst = 1'b0;
    bus.in_valid = '0;
    step();

    // Fill ch0 with consumer stalled, hold a fifth push, then drain
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 3'b001;
      set_data(0, 64'hA1 + 64'(i));
      step();
    end
    set_data(0, 64'hA5);
    #1;
    chk("full_count0", 64'(cnt_of(0)), 64'(4));
    chk("full_in_ready0", 64'(bus.in_ready[0]), 64'(0));
    chk("full_af0", 64'(bus.almost_full[0]), 64'(1));
    chk("full_head0", bus.out_data[0 +: PW], 64'hA1);
    step();
    bus.out_ready = 3'b001;
    step();
    #1;
    chk("pop_from_full_ready", 64'(bus.in_ready[0]), 64'(1));
    for (int i = 0; i < 6; i++) begin
      if (i == 1) bus.in_valid = '0;
      step();
    end
    chk("drained0", 64'(cnt_of(0)), 64'(0));

    // Continuous push+pop on ch1 across pointer wrap
    bus.in_valid  = 3'b010;
    bus.out_ready = 3'b010;
    for (int i = 1; i <= 10; i++) begin
      set_data(1, 64'(i));
      step();
      if (i > 1) chk("stream_head1", bus.out_data[PW +: PW], 64'(i));
    end
    #1;
    chk("stream_count1", 64'(cnt_of(1)), 64'(1));
    bus.in_valid = '0;
    step();

    // ch2 stalls to full while ch0 streams
    bus.in_valid  = 3'b101;
    bus.out_ready = 3'b001;
    for (int i = 0; i < 6; i++) begin
      set_data(0, 64'hC000 + 64'(i));
      set_data(2, 64'hB000 + 64'(i));
      step();
    end
    chk("indep_count2", 64'(cnt_of(2)), 64'(4));
    chk("indep_count0", 64'(cnt_of(0)), 64'(1));
    bus.in_valid  = '0;
    bus.out_ready = '1;
    repeat (5) step();

    // Flush with ch0 at 3 and ch1 at 2, while a push and a pop are requested
    bus.out_ready = '0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = (i < 2) ? 3'b011 : 3'b001;
      set_data(0, 64'hE0 + 64'(i));
      set_data(1, 64'hF0 + 64'(i));
      step();
    end
    flush = 1'b1;
    bus.in_valid  = 3'b001;
    bus.out_ready = 3'b010;
    set_data(0, 64'h77);
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'(0));
    chk("flush_out_valid", 64'(bus.out_valid), 64'(0));
    step();
    step();
    flush = 1'b0;
    bus.in_valid = '0;
    #1;
    chk("post_flush_count", 64'(bus.count), 64'(0));
    bus.in_valid = 3'b001;
    set_data(0, 64'h99);
    step();
    bus.in_valid = '0;
    #1;
    chk("post_flush_head", bus.out_data[0 +: PW], 64'h99);
    step();

    // Reset during traffic on a full ch0 overrides a simultaneous flush
    bus.out_ready = '0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 3'b001;
      set_data(0, 64'h5A0 + 64'(i));
      step();
    end
    rst = 1'b1;
    flush = 1'b1;
    bus.in_valid  = '1;
    bus.out_ready = '1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    bus.in_valid  = '0;
    bus.out_ready = '0;
    #1;
    chk("rst_traffic_in_ready", 64'(bus.in_ready), 64'(3'b111));
    chk("rst_traffic_out_data", 64'(bus.out_data[0 +: PW]), 64'(0));
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int c = 0; c < NCH; c++) begin
        bus.in_valid[c]  = ($urandom_range(0, 99) < 60);
        bus.out_ready[c] = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 75));
        set_data(c, {$urandom, $urandom});
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/issue_fifo.md
Name: issue_fifo

Overview:
Multi-channel, parametrised issue buffer between the reservation-station select logic and the execution units.
- Replaces the single-entry, no-backpressure hand-off with one FIFO per issue channel (default ALU, LS, Branch).
- Each channel has a ready/valid handshake on both sides, occupancy and almost-full outputs, and a global flush for branch mispredict.
- Selected entries are no longer lost when an execution unit stalls.

Parameters:
- NUM_CH, 3, number of independent issue channels (index 0 = ALU, 1 = LS, 2 = Branch).
- DEPTH, 4, entries per channel; power of two, >= 2.
- PAYLOAD_WIDTH, 64, bits per entry (packed RS_ENTRY_t width).
- AF_LEVEL, 3, occupancy at or above which almost_full asserts; 1 <= AF_LEVEL <= DEPTH.
- Derived CW = $clog2(DEPTH+1), the count width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries in all channels
- in_valid  in  NUM_CH  per-channel enqueue request
- in_ready  out  NUM_CH  per-channel space available
- in_data  in  NUM_CH*PAYLOAD_WIDTH  channel c at [c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]
- out_valid  out  NUM_CH  head entry present
- out_ready  in  NUM_CH  execution unit accepts head
- out_data  out  NUM_CH*PAYLOAD_WIDTH  head entry, same slicing as in_data
- count  out  NUM_CH*CW  per-channel occupancy
- almost_full  out  NUM_CH  count >= AF_LEVEL

Behaviour:
Clocking and reset
- One clock, clk. Reset rst is synchronous and active-high.
- On rst at a posedge: all read/write pointers and counts are set to 0.
- Resulting reset output values: out_valid=0, out_data=0, count=0, almost_full=0, in_ready all 1. rst takes priority over flush and over any handshake.

Handshake rules (per channel c, channels fully independent)
- in_ready[c] = (count[c] != DEPTH) && !flush. It depends only on registered state and flush; it has no combinational path from out_ready.
- out_valid[c] = (count[c] != 0) && !flush.
- out_data[c] is the head entry (first-word fall-through). It is driven to 0 whenever count[c] == 0.
- Enqueue occurs when in_valid[c] && in_ready[c]. Data is written at wr_ptr and wr_ptr advances by 1, modulo DEPTH.
- Dequeue occurs when out_valid[c] && out_ready[c]. rd_ptr advances by 1, modulo DEPTH.
- Count update: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- Latency: an entry enqueued into an empty channel at edge N is visible on out_valid/out_data after edge N.

Boundary conditions
- Full: in_ready=0. An in_valid asserted while full is not accepted; the producer must hold it.
- A dequeue from full does not make in_ready high in the same cycle; it becomes high on the next cycle.
- Empty: out_valid=0 and out_ready is ignored.
- Simultaneous enqueue and dequeue is allowed, including at count==1. At count==1 the old head leaves and the new entry becomes head next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full vs empty is distinguished by count, never by pointer equality.

Flush
- flush is sampled at the posedge. After that edge all pointers and counts of every channel are 0.
- In the flush cycle: in_ready=0 and out_valid=0, so no handshake completes. Storage contents are not cleared.
- Back-to-back flush cycles are allowed; outputs stay idle.

almost_full
- almost_full[c] = (count[c] >= AF_LEVEL). It is combinational from registered count and is not masked by flush.

Decomposition:
- Shared package (parameter_pkg): ISSUE_CH_ALU=0, ISSUE_CH_LS=1, ISSUE_CH_BR=2, ISSUE_NUM_CH=3, ISSUE_FIFO_DEPTH=4.
- typedef_pkg: RS_ENTRY_t stays there; its $bits sets PAYLOAD_WIDTH at the instantiation site.
- Sub-module issue_fifo_channel: a single-channel FIFO holding the storage array, pointers, count, handshake and flush logic. issue_fifo instantiates NUM_CH copies in a generate loop and only slices the packed buses.

Test Plan:
1. Reset: hold rst 2 cycles with in_valid=all 1 -> out_valid=0, count=0, in_ready=3'b111, out_data=0; no entry accepted.
2. Fill/drain ch0 (DEPTH=4, out_ready=0): enqueue 0xA1..0xA4 on 4 consecutive cycles -> count 1,2,3,4; almost_full rises at count=3; in_ready[0]=0 at count=4; a 5th push 0xA5 is held and not accepted. Then out_ready=1 -> heads 0xA1,0xA2,0xA3,0xA4 in order; in_ready[0] returns 1 the cycle after the first pop.
3. Wrap and simultaneous push/pop: ch1 with in_valid=out_ready=1 continuously for 10 cycles, data 1..10 -> count stays 1 after the first cycle; out_data sequence 1..9 lags input by 1 cycle; no loss across pointer wrap.
4. Channel independence: ch2 stalled (out_ready=0) until full while ch0 streams -> ch0 throughput is 1 per cycle; ch2 count=4; ch0 data is unaffected.
5. Flush mid-operation: ch0 count=3, ch1 count=2, flush=1 together with in_valid[0]=1 and out_ready[1]=1 -> in the flush cycle in_ready=0 and out_valid=0; next cycle all count=0 and the pushed entry is absent; a new push then appears as head 1 cycle later.
6. Reset during traffic: assert rst while ch0 is full and a push/pop is in flight -> next cycle all outputs are at reset values; rst overrides a simultaneous flush.
